// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-flag bit positions and the default flag-word width.
package cpu_pkg;
    localparam int FLAG_W_DEF = 4;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;
endpackage

// File: rtl/flag_stack.sv
// Parametrised LIFO holding saved flag words; qualifies push/pop and reports misuse events.
module flag_stack
    import cpu_pkg::*;
#(
    parameter int W           = FLAG_W_DEF,
    parameter int STACK_DEPTH = 4,
    parameter int CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          do_pop,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf_evt,
    output logic          unf_evt
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

    logic [W-1:0]  mem [STACK_DEPTH];
    logic [CW-1:0] top_idx;
    logic          do_push;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    // Simultaneous push and pop cancel out: nothing moves and no error is flagged.
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign ovf_evt = push & ~pop & full;
    assign unf_evt = pop & ~push & empty;
    assign top_idx = count - CW'(1);
    assign dout    = mem[top_idx[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CW'(1);
        end else if (do_pop) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[count[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/flag_register_unit.sv
// Status-flag register with per-bit write enables, shadow-stack save/restore and sticky misuse flags.
module flag_register_unit
    import cpu_pkg::*;
#(
    parameter int FLAG_W      = FLAG_W_DEF,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FLAG_W-1:0]                flags_in,
    input  logic [FLAG_W-1:0]                flags_we,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             clr_err,
    output logic [FLAG_W-1:0]                flags_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             ovf_err,
    output logic                             unf_err
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [FLAG_W-1:0] stack_top;
    logic [FLAG_W-1:0] flags_next;
    logic              do_pop;
    logic              ovf_evt;
    logic              unf_evt;

    flag_stack #(
        .W           (FLAG_W),
        .STACK_DEPTH (STACK_DEPTH),
        .CW          (CW)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (flags_out),
        .dout    (stack_top),
        .do_pop  (do_pop),
        .count   (stack_count),
        .full    (stack_full),
        .empty   (stack_empty),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    // A restore replaces the whole word and ignores the ALU write enables.
    always_comb begin
        flags_next = (flags_out & ~flags_we) | (flags_in & flags_we);
        if (do_pop) begin
            flags_next = stack_top;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_out <= '0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            flags_out <= flags_next;
            ovf_err   <= ovf_evt | (ovf_err & ~clr_err);
            unf_err   <= unf_evt | (unf_err & ~clr_err);
        end
    end
endmodule
